// File: rtl/mpc_sdiv_seq_30s_9s_21.sv
// Sequential signed divider: 30-bit dividend by 9-bit divisor, restoring
// shift-subtract one bit per enabled clock, saturating 21-bit quotient.
module mpc_sdiv_seq_30s_9s_21 #(
  parameter int din0_WIDTH = 30,
  parameter int din1_WIDTH = 9,
  parameter int dout_WIDTH = 21
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         start,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         ready,
  output logic                         done,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic signed [din1_WIDTH-1:0] rem,
  output logic                         ovf,
  output logic                         dbz
);

  localparam int CW = 5;
  localparam logic [CW-1:0] LAST_STEP = CW'(din0_WIDTH - 1);
  localparam logic [din0_WIDTH-1:0] POS_LIM = din0_WIDTH'((64'd1 << (dout_WIDTH - 1)) - 64'd1);
  localparam logic [din0_WIDTH-1:0] NEG_LIM = din0_WIDTH'(64'd1 << (dout_WIDTH - 1));
  localparam logic [dout_WIDTH-1:0] Q_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] Q_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t                  state;
  logic [CW-1:0]           count;
  logic                    steps_done;
  logic [din0_WIDTH-1:0]   dividend;
  logic [din0_WIDTH-1:0]   quot;
  logic [din1_WIDTH-1:0]   divisor;
  logic [din1_WIDTH-1:0]   part;
  logic                    q_neg;
  logic                    r_neg;

  logic [din0_WIDTH-1:0]   a_mag;
  logic [din1_WIDTH-1:0]   b_mag;
  logic [din1_WIDTH:0]     trial;
  logic [din1_WIDTH-1:0]   diff;
  logic                    fits;
  logic [dout_WIDTH-1:0]   neg_q;
  logic [dout_WIDTH-1:0]   fin_q;
  logic                    fin_ovf;
  logic [din1_WIDTH-1:0]   fin_rem;

  assign ready = (state != CALC);

  // Unsigned magnitudes; the most negative operands map to 2^(W-1) without wrap.
  assign a_mag = din0[din0_WIDTH-1] ? -din0 : din0;
  assign b_mag = din1[din1_WIDTH-1] ? -din1 : din1;

  // The true difference is below the divisor, so modular 9-bit subtraction is exact.
  assign trial = {part, dividend[din0_WIDTH-1]};
  assign fits  = (trial >= {1'b0, divisor});
  assign diff  = trial[din1_WIDTH-1:0] - divisor;

  assign neg_q = -quot[dout_WIDTH-1:0];

  always_comb begin
    fin_q   = quot[dout_WIDTH-1:0];
    fin_ovf = 1'b0;
    if (q_neg) begin
      if (quot > NEG_LIM) begin
        fin_q   = Q_MIN;
        fin_ovf = 1'b1;
      end else begin
        fin_q = neg_q;
      end
    end else if (quot > POS_LIM) begin
      fin_q   = Q_MAX;
      fin_ovf = 1'b1;
    end
    fin_rem = r_neg ? -part : part;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would chain the shift-subtract within one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      steps_done <= 1'b0;
      dividend   <= '0;
      quot       <= '0;
      divisor    <= '0;
      part       <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      done       <= 1'b0;
      dout       <= '0;
      rem        <= '0;
      ovf        <= 1'b0;
      dbz        <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE, FIN: begin
          done <= 1'b0;
          if (start) begin
            dividend   <= a_mag;
            divisor    <= b_mag;
            q_neg      <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
            r_neg      <= din0[din0_WIDTH-1];
            part       <= '0;
            quot       <= '0;
            count      <= LAST_STEP;
            steps_done <= 1'b0;
            if (din1 == '0) begin
              // Zero divisor skips the iteration and reports immediately.
              state <= FIN;
              done  <= 1'b1;
              dbz   <= 1'b1;
              ovf   <= 1'b1;
              rem   <= '0;
              dout  <= din0[din0_WIDTH-1] ? Q_MIN : Q_MAX;
            end else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (!steps_done) begin
            dividend <= dividend << 1;
            quot     <= {quot[din0_WIDTH-2:0], fits};
            part     <= fits ? diff : trial[din1_WIDTH-1:0];
            if (count == '0) steps_done <= 1'b1;
            else             count      <= count - 1'b1;
          end else begin
            state <= FIN;
            done  <= 1'b1;
            dout  <= fin_q;
            rem   <= fin_rem;
            ovf   <= fin_ovf;
            dbz   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpc_sdiv_seq_30s_9s_21.sv
// Directed bench for mpc_sdiv_seq_30s_9s_21: vector table plus hand-written
// sequences for clock-enable stalls, back-to-back starts and mid-operation reset.
module tb_mpc_sdiv_seq_30s_9s_21;

  logic               clk = 1'b0;
  logic               reset;
  logic               ce;
  logic               start;
  logic signed [29:0] din0;
  logic signed [8:0]  din1;
  logic               ready;
  logic               done;
  logic signed [20:0] dout;
  logic signed [8:0]  rem;
  logic               ovf;
  logic               dbz;

  int tests  = 0;
  int failed = 0;

  mpc_sdiv_seq_30s_9s_21 dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .start (start),
    .din0  (din0),
    .din1  (din1),
    .ready (ready),
    .done  (done),
    .dout  (dout),
    .rem   (rem),
    .ovf   (ovf),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [29:0] a;
    logic signed [8:0]  b;
    int                 q;
    int                 r;
    logic               ovf;
    logic               dbz;
    int                 lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic signed [63:0] actual,
                       input logic signed [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present operands at a negedge, let the next posedge capture them, then scramble inputs.
  task automatic launch(input logic signed [29:0] a, input logic signed [8:0] b);
    @(negedge clk);
    din0  = a;
    din1  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    din0  = 30'sd12345;
    din1  = -9'sd3;
  endtask

  // Posedges from the current point until done is seen high; bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int q, input int r,
                              input logic eo, input logic ed);
    check({tag, " dout"}, $signed(dout), q);
    check({tag, " rem"},  $signed(rem),  r);
    check({tag, " ovf"},  ovf, eo);
    check({tag, " dbz"},  dbz, ed);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int lat2;
    string tag;

    vecs.push_back('{30'sd1000,        9'sd7,    142,      6,   1'b0, 1'b0, 31});
    vecs.push_back('{-30'sd1000,       9'sd7,    -142,     -6,  1'b0, 1'b0, 31});
    vecs.push_back('{30'sd1000,        -9'sd7,   -142,     6,   1'b0, 1'b0, 31});
    vecs.push_back('{30'sd5242880,     9'sd1,    1048575,  0,   1'b1, 1'b0, 31});
    vecs.push_back('{-30'sd536870912,  -9'sd1,   1048575,  0,   1'b1, 1'b0, 31});
    vecs.push_back('{-30'sd536870912,  9'sd1,    -1048576, 0,   1'b1, 1'b0, 31});
    vecs.push_back('{30'sd5,           9'sd0,    1048575,  0,   1'b1, 1'b1, 0});
    vecs.push_back('{-30'sd5,          9'sd0,    -1048576, 0,   1'b1, 1'b1, 0});
    vecs.push_back('{30'sd100,         9'sd9,    11,       1,   1'b0, 1'b0, 31});
    vecs.push_back('{30'sd1048575,     9'sd1,    1048575,  0,   1'b0, 1'b0, 31});
    vecs.push_back('{-30'sd1048576,    9'sd1,    -1048576, 0,   1'b0, 1'b0, 31});
    vecs.push_back('{-30'sd1048577,    9'sd1,    -1048576, 0,   1'b1, 1'b0, 31});
    vecs.push_back('{30'sd536870911,   -9'sd256, -1048576, 255, 1'b1, 1'b0, 31});
    vecs.push_back('{30'sd300000,      -9'sd256, -1171,    224, 1'b0, 1'b0, 31});
    vecs.push_back('{-30'sd7,          9'sd255,  0,        -7,  1'b0, 1'b0, 31});

    reset = 1'b1;
    ce    = 1'b1;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    #12;
    check("reset ready", ready, 1'b1);
    check("reset done",  done,  1'b0);
    check_result("reset", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      tag = $sformatf("vec%0d", i);
      launch(vecs[i].a, vecs[i].b);
      if (vecs[i].lat != 0) begin
        check({tag, " busy ready"}, ready, 1'b0);
        check({tag, " busy done"},  done,  1'b0);
      end
      wait_done(lat);
      check({tag, " latency"}, lat, vecs[i].lat);
      check_result(tag, vecs[i].q, vecs[i].r, vecs[i].ovf, vecs[i].dbz);
      @(posedge clk);
      #1;
      check({tag, " done pulse ends"}, done, 1'b0);
      check({tag, " idle ready"}, ready, 1'b1);
      check({tag, " dout holds"}, $signed(dout), vecs[i].q);
    end

    // Clock-enable stall plus an ignored start pulse while busy.
    launch(30'sd1000, 9'sd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    din0  = 30'sd50;
    din1  = 9'sd3;
    @(negedge clk);
    start = 1'b0;
    ce    = 1'b0;
    repeat (10) @(negedge clk);
    check("stall ready", ready, 1'b0);
    check("stall done",  done,  1'b0);
    ce = 1'b1;
    wait_done(lat2);
    check("stall latency", 4 + 10 + lat2, 41);
    check_result("stall", 142, 6, 1'b0, 1'b0);

    // Back-to-back: start while in FIN, done falls and the next result arrives.
    launch(-30'sd1000, 9'sd7);
    check("b2b done falls", done,  1'b0);
    check("b2b busy",       ready, 1'b0);
    wait_done(lat);
    check("b2b latency", lat, 31);
    check_result("b2b", -142, -6, 1'b0, 1'b0);
    launch(30'sd5, 9'sd0);
    check("b2b dbz done stays", done, 1'b1);
    check_result("b2b dbz", 1048575, 0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("b2b dbz idle", done, 1'b0);
    check_result("b2b dbz hold", 1048575, 0, 1'b1, 1'b1);

    // Reset mid-iteration: asynchronous clear, no stale done, next start accepted at once.
    launch(30'sd100000, 9'sd3);
    repeat (15) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst ready", ready, 1'b1);
    check("midrst done",  done,  1'b0);
    check_result("midrst", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    din0  = 30'sd100;
    din1  = 9'sd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("post-reset accept", ready, 1'b0);
    wait_done(lat);
    check("post-reset latency", lat, 31);
    check_result("post-reset", 11, 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mpc_sdiv_seq_30s_9s_21.md
MPC_SDIV_SEQ_30S_9S_21 -- requirements
Module: mpc_sdiv_seq_30s_9s_21

Interface
REQ-001 SHALL provide parameters: din0_WIDTH, 30, dividend width; din1_WIDTH, 9, divisor width; dout_WIDTH, 21, quotient width.
REQ-002 SHALL provide port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL provide port ce, input, 1, clock enable; when low, all registers and outputs hold.
REQ-005 SHALL provide port start, input, 1, request to begin a division; sampled only when ready=1 and ce=1.
REQ-006 SHALL provide port din0, input, 30, signed two's-complement dividend, captured with start.
REQ-007 SHALL provide port din1, input, 9, signed two's-complement divisor, captured with start.
REQ-008 SHALL provide port ready, output, 1, high when a start will be accepted.
REQ-009 SHALL provide port done, output, 1, one-ce-cycle pulse marking valid results.
REQ-010 SHALL provide port dout, output, 21, signed quotient.
REQ-011 SHALL provide port rem, output, 9, signed remainder.
REQ-012 SHALL provide port ovf, output, 1, quotient saturated.
REQ-013 SHALL provide port dbz, output, 1, divisor was zero.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIN; ready=1 in IDLE and FIN, 0 in CALC.
REQ-015 On a ce edge with start=1 and ready=1, SHALL capture operands, record signs, form unsigned magnitudes, load a 5-bit iteration counter with 29, and enter CALC.
REQ-016 In CALC, SHALL perform one restoring shift-subtract step per ce edge, MSB first, for 30 steps; after the step with counter=0, SHALL enter FIN.
REQ-017 On the FIN-entry edge, SHALL register dout, rem, ovf, dbz and set done=1; done SHALL be high exactly while in FIN.
REQ-018 Latency: done SHALL be high in the cycle following the 31st ce-enabled edge after the capture edge; ce-low cycles extend latency one for one.
REQ-019 Quotient SHALL truncate toward zero; quotient sign = sign(din0) XOR sign(din1); rem sign SHALL equal sign(din0), with |rem| < |din1|.
REQ-020 If the signed quotient lies outside [-1048576, 1048575], dout SHALL saturate to the nearest bound and ovf=1; otherwise ovf=0.
REQ-021 If din1=0 at capture, SHALL bypass CALC, enter FIN on the next ce edge, with dbz=1, ovf=1, rem=0, dout=1048575 if din0>=0 else -1048576.
REQ-022 din0=-536870912 SHALL be handled via 30-bit unsigned magnitude 2^29 without wrap.
REQ-023 start while in CALC SHALL be ignored, with no effect on the running operation.
REQ-024 start in FIN SHALL be accepted (back-to-back); next state CALC (or FIN for zero divisor), done falls accordingly.
REQ-025 From FIN without start, SHALL return to IDLE on the next ce edge; dout, rem, ovf, dbz SHALL hold until the next FIN entry.
REQ-026 din0/din1 changes after capture SHALL NOT affect the result.

Reset
REQ-027 reset=1 SHALL immediately, independent of clk and ce, force state IDLE, counter 0, done=0, ready=1, dout=0, rem=0, ovf=0, dbz=0.
REQ-028 Reset asserted during CALC SHALL abandon the operation; no done pulse SHALL follow for it.
REQ-029 First start SHALL be accepted on the first ce edge after reset deasserts.

Verification
REQ-030 din0=1000, din1=7, ce=1 -> done in cycle after 31st edge post-capture; dout=142, rem=6, ovf=0, dbz=0.
REQ-031 din0=-1000, din1=7 -> dout=-142, rem=-6; din0=1000, din1=-7 -> dout=-142, rem=6.
REQ-032 din0=5242880, din1=1 -> dout=1048575, ovf=1, rem=0; din0=-536870912, din1=-1 -> dout=1048575, ovf=1.
REQ-033 din0=5, din1=0 -> done in cycle after capture edge; dbz=1, ovf=1, dout=1048575, rem=0; din0=-5, din1=0 -> dout=-1048576.
REQ-034 ce held low 10 cycles mid-CALC -> done delayed exactly 10 cycles, result unchanged; start pulsed during CALC with other operands -> ignored.
REQ-035 reset pulsed at iteration 15 -> all outputs zero, ready=1, no done; subsequent 100/9 -> dout=11, rem=1.
